// File: rtl/tk1_mmio_xbar.sv
// tk1_mmio_xbar: MMIO interconnect between the CPU memory bus and NUM_CORES
// peripheral cores. A request is decoded once on its first valid edge by the
// 6-bit core prefix in cpu_addr[29:24], then either answered directly
// (unmapped or denied prefix) or forwarded to exactly one core until that core
// reports ready or the access times out. Errors are captured in a sticky
// register where the first error wins.
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   fw_app_mode        1 = application mode (cores in APP_DENY_MASK are denied)
//   cpu_valid/addr/wstrb/wdata   CPU request, held until cpu_ready
//   cpu_ready/rdata    one-cycle response strobe and read data
//   core_cs/we/address/wdata     one-hot select and latched request to the cores
//   core_rdata/ready   per-core read data (32 bits per core) and ready
//   err_valid/cause/addr         sticky error record (01 denied, 10 timeout)
//   err_clear          clears err_valid
module tk1_mmio_xbar #(
  parameter int                     NUM_CORES      = 8,
  parameter logic [NUM_CORES*6-1:0] CORE_PREFIXES  = {6'h3f, 6'h10, 6'h04, 6'h03,
                                                      6'h02, 6'h01, 6'h00, 6'h05},
  parameter logic [NUM_CORES-1:0]   APP_DENY_MASK  = 8'h04,
  parameter int                     TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fw_app_mode,
  input  logic                    cpu_valid,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_wstrb,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  output logic [NUM_CORES-1:0]    core_cs,
  output logic                    core_we,
  output logic [7:0]              core_address,
  output logic [31:0]             core_wdata,
  input  logic [NUM_CORES*32-1:0] core_rdata,
  input  logic [NUM_CORES-1:0]    core_ready,
  output logic                    err_valid,
  output logic [1:0]              err_cause,
  output logic [31:0]             err_addr,
  input  logic                    err_clear
);

  localparam int IDXW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_DENIED  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q;
  logic [NUM_CORES-1:0]   cs_q;
  logic                   we_q;
  logic [7:0]             caddr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            addr_q;
  logic [31:0]            rdata_q;
  logic                   ready_q;
  logic [15:0]            cnt_q;
  logic [IDXW-1:0]        idx_q;
  logic                   errValid_q, errValid_d;
  logic [1:0]             errCause_q, errCause_d;
  logic [31:0]            errAddr_q, errAddr_d;

  logic                   hit;
  logic [IDXW-1:0]        hitIdx;
  logic                   denied;
  logic                   selReady;
  logic [31:0]            selRdata;
  logic                   timeoutHit;
  logic                   raiseErr;
  logic [1:0]             raiseCause;
  logic [31:0]            raiseAddr;

  // Prefix decode: scanning from the top down lets the lowest matching index
  // overwrite any higher duplicate, so higher duplicates are unreachable.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (CORE_PREFIXES[6*i +: 6] == cpu_addr[29:24]) begin
        hit    = 1'b1;
        hitIdx = IDXW'(i);
      end
    end
  end

  assign denied = hit && fw_app_mode && APP_DENY_MASK[hitIdx];

  // Only the latched core's ready and read data are looked at.
  always_comb begin
    selReady = 1'b0;
    selRdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (idx_q == IDXW'(i)) begin
        selReady = core_ready[i];
        selRdata = core_rdata[32*i +: 32];
      end
    end
  end

  assign timeoutHit = (state_q == ACCESS) && !selReady && (cnt_q == CNT_LAST);

  // Error sources: a denial is reported at decode with the live address, a
  // timeout at the last ACCESS cycle with the latched address.
  always_comb begin
    raiseErr   = 1'b0;
    raiseCause = '0;
    raiseAddr  = '0;
    if (state_q == IDLE && cpu_valid && denied) begin
      raiseErr   = 1'b1;
      raiseCause = CAUSE_DENIED;
      raiseAddr  = cpu_addr;
    end else if (timeoutHit) begin
      raiseErr   = 1'b1;
      raiseCause = CAUSE_TIMEOUT;
      raiseAddr  = addr_q;
    end
  end

  // Sticky error record: first error wins, and an error arriving together
  // with err_clear is still captured because the clear frees the slot first.
  always_comb begin
    errValid_d = errValid_q;
    errCause_d = errCause_q;
    errAddr_d  = errAddr_q;
    if (err_clear) begin
      errValid_d = 1'b0;
    end
    if (raiseErr && (!errValid_q || err_clear)) begin
      errValid_d = 1'b1;
      errCause_d = raiseCause;
      errAddr_d  = raiseAddr;
    end
  end

  // Access FSM with registered outputs; cpu_ready is only ever set on the
  // transition into RESP, so it is high for exactly the one RESP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cs_q       <= '0;
      we_q       <= 1'b0;
      caddr_q    <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      errValid_q <= 1'b0;
      errCause_q <= '0;
      errAddr_q  <= '0;
    end else begin
      ready_q    <= 1'b0;
      errValid_q <= errValid_d;
      errCause_q <= errCause_d;
      errAddr_q  <= errAddr_d;
      case (state_q)
        IDLE: begin
          if (cpu_valid) begin
            addr_q  <= cpu_addr;
            caddr_q <= cpu_addr[9:2];
            wdata_q <= cpu_wdata;
            we_q    <= |cpu_wstrb;
            idx_q   <= hitIdx;
            cnt_q   <= '0;
            if (!hit || denied) begin
              rdata_q <= '0;
              ready_q <= 1'b1;
              state_q <= RESP;
            end else begin
              cs_q    <= NUM_CORES'(1) << hitIdx;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (selReady) begin
            rdata_q <= selRdata;
            cs_q    <= '0;
            ready_q <= 1'b1;
            state_q <= RESP;
          end else if (timeoutHit) begin
            rdata_q <= '0;
            cs_q    <= '0;
            ready_q <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready    = ready_q;
  assign cpu_rdata    = rdata_q;
  assign core_cs      = cs_q;
  assign core_we      = we_q;
  assign core_address = caddr_q;
  assign core_wdata   = wdata_q;
  assign err_valid    = errValid_q;
  assign err_cause    = errCause_q;
  assign err_addr     = errAddr_q;

endmodule

// File: tb/tb_tk1_mmio_xbar.sv
// tb_tk1_mmio_xbar: directed, table-driven bench for tk1_mmio_xbar.
// Two instances share the core-side stimulus: dutA uses the normal timeout,
// dutB a 4-cycle timeout. Both use a prefix table where cores 0..4 answer at
// prefixes 00..04, core 6 at 10, core 7 at 3f, and core 5 duplicates prefix 01
// (so it must never be selected). Prefix 05 and 20 are unmapped.
module tb_tk1_mmio_xbar;

  localparam int N = 8;
  localparam logic [N*6-1:0] PREFIXES = {6'h3f, 6'h10, 6'h01, 6'h04,
                                         6'h03, 6'h02, 6'h01, 6'h00};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fw_app_mode = 1'b0;
  logic          validDrv = 1'b0;
  logic          sel = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [3:0]    cpu_wstrb = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [N*32-1:0] core_rdata = '0;
  logic [N-1:0]  core_ready = '0;
  logic          err_clear = 1'b0;

  logic          validA, validB;
  logic          readyA, readyB, weA, weB, errVA, errVB;
  logic [31:0]   rdataA, rdataB, wdataA, wdataB, errAddrA, errAddrB;
  logic [N-1:0]  csA, csB;
  logic [7:0]    caddrA, caddrB;
  logic [1:0]    causeA, causeB;

  int total = 0;
  int bad   = 0;

  assign validA = validDrv & ~sel;
  assign validB = validDrv & sel;

  always #5 clk = ~clk;

  tk1_mmio_xbar #(.NUM_CORES(N), .CORE_PREFIXES(PREFIXES), .APP_DENY_MASK(8'h04),
                  .TIMEOUT_CYCLES(255)) dutA (
    .clk(clk), .reset_n(reset_n), .fw_app_mode(fw_app_mode), .cpu_valid(validA),
    .cpu_addr(cpu_addr), .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
    .cpu_ready(readyA), .cpu_rdata(rdataA), .core_cs(csA), .core_we(weA),
    .core_address(caddrA), .core_wdata(wdataA), .core_rdata(core_rdata),
    .core_ready(core_ready), .err_valid(errVA), .err_cause(causeA),
    .err_addr(errAddrA), .err_clear(err_clear));

  tk1_mmio_xbar #(.NUM_CORES(N), .CORE_PREFIXES(PREFIXES), .APP_DENY_MASK(8'h04),
                  .TIMEOUT_CYCLES(4)) dutB (
    .clk(clk), .reset_n(reset_n), .fw_app_mode(fw_app_mode), .cpu_valid(validB),
    .cpu_addr(cpu_addr), .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
    .cpu_ready(readyB), .cpu_rdata(rdataB), .core_cs(csB), .core_we(weB),
    .core_address(caddrB), .core_wdata(wdataB), .core_rdata(core_rdata),
    .core_ready(core_ready), .err_valid(errVB), .err_cause(causeB),
    .err_addr(errAddrB), .err_clear(err_clear));

  logic          obsReady, obsWe, obsErrV;
  logic [31:0]   obsRdata, obsWdata, obsErrAddr;
  logic [N-1:0]  obsCs;
  logic [7:0]    obsCaddr;
  logic [1:0]    obsCause;

  assign obsReady   = sel ? readyB   : readyA;
  assign obsRdata   = sel ? rdataB   : rdataA;
  assign obsCs      = sel ? csB      : csA;
  assign obsWe      = sel ? weB      : weA;
  assign obsCaddr   = sel ? caddrB   : caddrA;
  assign obsWdata   = sel ? wdataB   : wdataA;
  assign obsErrV    = sel ? errVB    : errVA;
  assign obsCause   = sel ? causeB   : causeA;
  assign obsErrAddr = sel ? errAddrB : errAddrA;

  typedef struct {
    string       name;
    logic        useB;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        app;
    logic        appFlip;
    logic        clr;
    int          readyAt;
    logic [31:0] coreData;
    logic [7:0]  expCs;
    int          expLat;
    int          expCsCycles;
    logic [31:0] expRdata;
    logic        expErrV;
    logic [1:0]  expCause;
    logic [31:0] expErrAddr;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Runs one CPU transaction: readyAt = ACCESS cycle in which the selected
  // core raises ready (0 = never); non-selected cores keep ready high as noise.
  task automatic applyStimulus(input vec_t v);
    int csCount = 0;
    int lat = 0;
    int got = 0;
    int stableErr = 0;
    logic [7:0]  csOr = '0;
    logic [31:0] gotRdata = '0;
    for (int i = 0; i < N; i++)
      core_rdata[32*i +: 32] = v.expCs[i] ? v.coreData : (32'hEEEE_0000 | 32'(i));
    sel         = v.useB;
    cpu_addr    = v.addr;
    cpu_wstrb   = v.wstrb;
    cpu_wdata   = v.wdata;
    fw_app_mode = v.app;
    err_clear   = v.clr;
    core_ready  = ~v.expCs;
    validDrv    = 1'b1;
    for (int k = 1; k <= 300 && got == 0; k++) begin
      @(posedge clk); #1;
      err_clear = 1'b0;
      if (v.appFlip && k == 1) fw_app_mode = ~v.app;
      csOr = csOr | obsCs;
      if (obsCs != '0) begin
        csCount++;
        if (obsCaddr !== v.addr[9:2] || obsWdata !== v.wdata || obsWe !== (|v.wstrb))
          stableErr++;
      end
      if (obsReady) begin
        got      = 1;
        lat      = k;
        gotRdata = obsRdata;
        validDrv = 1'b0;
      end
      core_ready = (v.readyAt != 0 && csCount == v.readyAt) ? v.expCs : ~v.expCs;
    end
    validDrv = 1'b0;
    checkOutput({v.name, " responded"}, 32'(got), 32'd1);
    checkOutput({v.name, " latency"}, lat, v.expLat);
    checkOutput({v.name, " cs_seen"}, 32'(csOr), 32'(v.expCs));
    checkOutput({v.name, " cs_cycles"}, csCount, v.expCsCycles);
    checkOutput({v.name, " rdata"}, gotRdata, v.expRdata);
    checkOutput({v.name, " req_stable"}, stableErr, 0);
    @(posedge clk); #1;
    checkOutput({v.name, " single_ready"}, 32'(obsReady), 32'd0);
    checkOutput({v.name, " err_valid"}, 32'(obsErrV), 32'(v.expErrV));
    checkOutput({v.name, " err_cause"}, 32'(obsCause), 32'(v.expCause));
    checkOutput({v.name, " err_addr"}, obsErrAddr, v.expErrAddr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int readySeen;
    //        name           B  addr          wstrb wdata         app flp clr rdy data          cs     lat cc rdata         eV cause errAddr
    vecs[0]  = '{"rd_core1",   0, 32'hC100_0008, 4'h0, 32'h0,        0, 0, 0, 1, 32'h1234_5678, 8'h02, 2, 1, 32'h1234_5678, 0, 2'b00, 32'h0};
    vecs[1]  = '{"wr_core6",   0, 32'hD000_0010, 4'hF, 32'hA5A5_A5A5, 0, 0, 0, 5, 32'h5A5A_0000, 8'h40, 6, 5, 32'h5A5A_0000, 0, 2'b00, 32'h0};
    vecs[2]  = '{"rd_core7",   0, 32'hFF00_03FC, 4'h0, 32'h0,        0, 0, 0, 2, 32'hDEAD_BEEF, 8'h80, 3, 2, 32'hDEAD_BEEF, 0, 2'b00, 32'h0};
    vecs[3]  = '{"rd_core4",   0, 32'hC400_0000, 4'h0, 32'h0,        0, 0, 0, 1, 32'hCAFE_F00D, 8'h10, 2, 1, 32'hCAFE_F00D, 0, 2'b00, 32'h0};
    vecs[4]  = '{"unmap_20",   0, 32'hE000_0000, 4'h0, 32'h0,        0, 0, 0, 0, 32'h0,         8'h00, 1, 0, 32'h0,         0, 2'b00, 32'h0};
    vecs[5]  = '{"unmap_05",   0, 32'hC500_0000, 4'h1, 32'h0000_0099, 0, 0, 0, 0, 32'h0,         8'h00, 1, 0, 32'h0,         0, 2'b00, 32'h0};
    vecs[6]  = '{"app_core1",  0, 32'hC100_0004, 4'h0, 32'h0,        1, 0, 0, 1, 32'h0BAD_F00D, 8'h02, 2, 1, 32'h0BAD_F00D, 0, 2'b00, 32'h0};
    vecs[7]  = '{"denied",     0, 32'hC200_0000, 4'h0, 32'h0,        1, 0, 0, 0, 32'h0,         8'h00, 1, 0, 32'h0,         1, 2'b01, 32'hC200_0000};
    vecs[8]  = '{"core2_kern", 0, 32'hC200_0040, 4'h3, 32'h1122_3344, 0, 0, 0, 1, 32'h5566_7788, 8'h04, 2, 1, 32'h5566_7788, 1, 2'b01, 32'hC200_0000};
    vecs[9]  = '{"denied_2nd", 0, 32'hC200_0100, 4'h0, 32'h0,        1, 0, 0, 0, 32'h0,         8'h00, 1, 0, 32'h0,         1, 2'b01, 32'hC200_0000};
    vecs[10] = '{"core2_flip", 0, 32'hC200_0080, 4'h0, 32'h0,        0, 1, 0, 3, 32'h7777_8888, 8'h04, 4, 3, 32'h7777_8888, 1, 2'b01, 32'hC200_0000};

    // Reset state
    #12;
    checkOutput("reset cpu_ready", 32'(readyA), 32'd0);
    checkOutput("reset core_cs", 32'(csA), 32'd0);
    checkOutput("reset cpu_rdata", rdataA, 32'd0);
    checkOutput("reset err_valid", 32'(errVA), 32'd0);
    checkOutput("reset err_addr", errAddrA, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // err_clear alone drops the sticky flag
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    checkOutput("clear err_valid", 32'(errVA), 32'd0);

    // Timeout on core 0 with the 4-cycle instance, then a denied access must
    // not overwrite the timeout, then a denied access with err_clear must.
    applyStimulus('{"timeout",    1, 32'hC000_0000, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 8'h01, 5, 4, 32'h0, 1, 2'b10, 32'hC000_0000});
    applyStimulus('{"deny_after", 1, 32'hC200_0000, 4'h0, 32'h0, 1, 0, 0, 0, 32'h0, 8'h00, 1, 0, 32'h0, 1, 2'b10, 32'hC000_0000});
    applyStimulus('{"deny_clr",   1, 32'hC200_0020, 4'h0, 32'h0, 1, 0, 1, 0, 32'h0, 8'h00, 1, 0, 32'h0, 1, 2'b01, 32'hC200_0020});
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    checkOutput("B clear err_valid", 32'(errVB), 32'd0);

    // Reset between clock edges in the middle of an access
    sel         = 1'b0;
    fw_app_mode = 1'b0;
    cpu_addr    = 32'hC100_0000;
    cpu_wstrb   = 4'h0;
    core_ready  = '0;
    validDrv    = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_access cs", 32'(csA), 32'h02);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst cs", 32'(csA), 32'd0);
    checkOutput("async_rst ready", 32'(readyA), 32'd0);
    validDrv = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    readySeen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (readyA || csA != '0) readySeen++;
    end
    checkOutput("post_rst quiet", readySeen, 0);
    applyStimulus(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tk1_mmio_xbar.md
Name: tk1_mmio_xbar

Overview:
- Parametrised MMIO interconnect between the CPU memory bus and N peripheral cores in the MMIO area.
- Successor to the fixed per-core decode in the top level. Core count and prefix table are parameters.
- Adds app-mode access denial per core, a per-access ready timeout, and a sticky error-capture register.
- The top level instantiates it for area prefix 2'h3; ROM/RAM decode stays in the top level.

Parameters:
- NUM_CORES, 8, number of core ports (1..32)
- CORE_PREFIXES, {6'h3f,6'h10,6'h04,6'h03,6'h02,6'h01,6'h00,6'h05}, flat NUM_CORES*6 table; entry i = bits [6i+5:6i]
- APP_DENY_MASK, 8'h04, bit i set = core i inaccessible when fw_app_mode=1
- TIMEOUT_CYCLES, 255, max ACCESS cycles without core ready (1..65535)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- fw_app_mode  in  1  1 = application mode
- cpu_valid  in  1  request, held until cpu_ready
- cpu_addr  in  32  byte address; [29:24] core prefix, [9:2] word address
- cpu_wstrb  in  4  byte write strobes; 0 = read
- cpu_wdata  in  32  write data
- cpu_ready  out  1  one-cycle response strobe
- cpu_rdata  out  32  read data, valid with cpu_ready
- core_cs  out  NUM_CORES  one-hot select
- core_we  out  1  |wstrb of the latched request
- core_address  out  8  latched cpu_addr[9:2]
- core_wdata  out  32  latched write data
- core_rdata  in  NUM_CORES*32  per-core read data, slice i = [32i+31:32i]
- core_ready  in  NUM_CORES  per-core ready
- err_valid  out  1  sticky error flag
- err_cause  out  2  01 = denied, 10 = timeout
- err_addr  out  32  address of the first captured error
- err_clear  in  1  clears the error register

Behaviour:
- All outputs are registered. Async reset forces state=IDLE and zeroes every output, timeout counter and latched field, independent of clk. A reset mid-access drops core_cs in the same cycle, and no cpu_ready follows.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on a clk edge with cpu_valid=1:
  - Latch addr, wdata and wstrb.
  - Decode index = lowest i with CORE_PREFIXES[i]==cpu_addr[29:24].
  - No match: go to RESP with rdata=0 and no error.
  - Match with fw_app_mode=1 and APP_DENY_MASK[i]=1: go to RESP with rdata=0 and raise a denied error. core_cs is never asserted.
  - Otherwise: go to ACCESS with core_cs[i]=1 and the timeout counter set to 0.
- ACCESS:
  - core_cs[i], core_we, core_address and core_wdata are held stable.
  - core_ready[i]=1 at an edge: capture core_rdata slice i into cpu_rdata, drop core_cs, go to RESP.
  - Ready and rdata from non-selected cores are ignored.
  - Counter increments each cycle. When counter == TIMEOUT_CYCLES-1 with no ready: drop core_cs, cpu_rdata=0, raise a timeout error, go to RESP.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE. cpu_ready is never high in IDLE or ACCESS.
- Latency: cpu_valid seen at edge 0, core ready in the first ACCESS cycle, cpu_ready high in the cycle after edge 1 (2 cycles to response). Unmapped or denied accesses take 1 cycle to response.
- fw_app_mode is sampled only at decode. A change during ACCESS does not abort the access.
- Error register:
  - A raised error loads err_valid=1, err_cause and err_addr only if err_valid=0 (first error wins).
  - err_clear=1 clears err_valid at the edge.
  - A new error raised in the same cycle as err_clear is captured (set wins).
  - err_cause and err_addr hold their values while err_valid=1.
- Duplicate prefixes: the lower index wins. Higher duplicates are unreachable.

Test Plan:
- Read core 1 (addr 0xC100_0008), core ready in first ACCESS cycle, rdata 0x1234_5678 -> core_cs=0x02, core_address=8'h02, cpu_ready 2 cycles after valid with rdata 0x1234_5678, err_valid=0.
- Write 0xA5A5_A5A5 with wstrb=4'hF to prefix 6'h10 (core 6), core ready after 5 cycles -> core_we=1, core_wdata stable for all 5 cycles, exactly one cpu_ready pulse.
- fw_app_mode=1, read 0xC200_0000 (core 2, denied) -> core_cs never set, cpu_rdata=0, err_valid=1, err_cause=01, err_addr=0xC200_0000.
- TIMEOUT_CYCLES=4, core 0 never ready -> core_cs high for 4 cycles, cpu_rdata=0, err_cause=10. A following denied access leaves err_cause=10. err_clear then clears err_valid.
- Unmapped prefix 6'h20 -> cpu_ready after 1 cycle, rdata=0, no core_cs, no error.
- reset_n low mid-ACCESS, between clk edges -> core_cs=0 immediately, no cpu_ready after release, state IDLE.
